calc_driver: RTL and testbench

Command-driven front end for the `calc` accumulator block, acting from the other side of its button/switch/LED interface. It accepts one operation per valid/ready handshake and drives `sw` and the opcode buttons with parameterised setup, pulse and settle phases. It pulses `btnd` (enter) or `btnu` (clear), then samples `led` and returns it on a valid/ready response channel. It sits between a host-side sequencer or test controller and a `calc` instance, and replaces hand-timed button stimulus.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_drv_timer.sv | 19 +
 rtl/calc_driver.sv | 109 ++++++++++
 tb/tb_calc_driver.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: opcodes, driver FSM states and phase-counter sizing shared by calc_driver
package calc_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LT  = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, SETTLE, RESP} state_t;

  function automatic int calc_cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/calc_drv_timer.sv
// calc_drv_timer: loadable phase down-counter; o_done flags the last cycle of a phase
module calc_drv_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);
  logic [W-1:0] r_cnt;

  assign o_done = r_cnt == '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (!o_done) r_cnt <= r_cnt - W'(1);
endmodule

// File: rtl/calc_driver.sv
// calc_driver: command front end pulsing calc buttons and returning led; CALC_DRV_OPCOUNT_EN adds op_count
module calc_driver
  import calc_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 1,
  parameter int SETTLE_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_clr,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        btnl,
  output logic        btnc,
  output logic        btnr,
  output logic        btnd,
  output logic        btnu,
  output logic [15:0] sw,
  input  logic [15:0] led
`ifdef CALC_DRV_OPCOUNT_EN
  ,output logic [15:0] op_count
`endif
);
  localparam int CW = calc_cnt_w(SETUP_CYC, PULSE_CYC, SETTLE_CYC);

  state_t        r_state, w_next;
  logic          w_load, w_done, w_acc, w_tgt;
  logic [CW-1:0] w_val;
  logic          r_clr, r_btnd, r_btnu;
  logic [2:0]    r_op;
  logic [15:0]   r_sw, r_rsp;

  assign w_acc = (r_state == IDLE) && cmd_valid;
  // pulse target is decided at accept time and held for the whole transaction
  assign w_tgt = w_acc ? cmd_clr : r_clr;

  assign cmd_ready = r_state == IDLE;
  assign rsp_valid = r_state == RESP;
  assign rsp_data  = r_rsp;
  assign {btnl, btnc, btnr} = r_op;
  assign btnd = r_btnd;
  assign btnu = r_btnu;
  assign sw   = r_sw;

  calc_drv_timer #(.W(CW)) u_timer (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_val(w_val), .o_done(w_done)
  );

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_val  = '0;
    case (r_state)
      IDLE: if (cmd_valid) begin
        w_next = cmd_clr ? PULSE : SETUP;
        w_load = 1'b1;
        w_val  = cmd_clr ? CW'(PULSE_CYC - 1) : CW'(SETUP_CYC - 1);
      end
      SETUP: if (w_done) begin
        w_next = PULSE;
        w_load = 1'b1;
        w_val  = CW'(PULSE_CYC - 1);
      end
      PULSE: if (w_done) begin
        w_next = SETTLE;
        w_load = 1'b1;
        w_val  = CW'(SETTLE_CYC - 1);
      end
      SETTLE: w_next = w_done ? RESP : SETTLE;
      RESP: w_next = rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_clr   <= 1'b0;
      r_btnd  <= 1'b0;
      r_btnu  <= 1'b0;
      r_op    <= '0;
      r_sw    <= '0;
      r_rsp   <= '0;
    end else begin
      r_state <= w_next;
      r_btnd  <= (w_next == PULSE) && !w_tgt;
      r_btnu  <= (w_next == PULSE) && w_tgt;
      if (w_acc) r_clr <= cmd_clr;
      if (w_acc && !cmd_clr) begin
        r_op <= cmd_op;
        r_sw <= cmd_data;
      end
      if (r_state == SETTLE && w_done) r_rsp <= led;
    end

`ifdef CALC_DRV_OPCOUNT_EN
  logic [15:0] r_opcnt;
  assign op_count = r_opcnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_opcnt <= '0;
    else if (w_acc) r_opcnt <= cmd_clr ? 16'h0000 : r_opcnt + 16'h0001;
`endif
endmodule

// File: tb/tb_calc_driver.sv
// tb_calc_driver: vector table and corner sequences for calc_driver against a behavioural calc
module tb_calc_driver;
  localparam int S = 2, P = 3, T = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_clr = 1'b0, rsp_ready = 1'b1;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_data = 16'h0000;
  logic        cmd_ready, rsp_valid, btnl, btnc, btnr, btnd, btnu;
  logic [15:0] rsp_data, sw, led;
`ifdef CALC_DRV_OPCOUNT_EN
  logic [15:0] op_count;
`endif

  int checks = 0, errors = 0;
  logic [15:0] sb[$];

  calc_driver #(.SETUP_CYC(S), .PULSE_CYC(P), .SETTLE_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_clr(cmd_clr), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .btnl(btnl), .btnc(btnc), .btnr(btnr), .btnd(btnd), .btnu(btnu),
    .sw(sw), .led(led)
`ifdef CALC_DRV_OPCOUNT_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  // behavioural calc: acts on rising edges of enter and clear
  logic [15:0] acc = 16'h5a5a;
  logic        btnd_q = 1'b0, btnu_q = 1'b0;
  assign led = acc;

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return a + b;
      3'b011: return a - b;
      3'b100: return {15'd0, a < b};
      3'b101: return a << b[3:0];
      3'b110: return $signed(a) >>> b[3:0];
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    btnd_q <= btnd;
    btnu_q <= btnu;
    if (btnu && !btnu_q) acc <= 16'h0000;
    else if (btnd && !btnd_q) acc <= alu({btnl, btnc, btnr}, acc, sw);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", {15'd0, rsp_valid}, 32'd0);
      else chk("rsp_data", {16'd0, rsp_data}, {16'd0, sb.pop_front()});
    end

  task automatic send(input logic c, input logic [2:0] op, input logic [15:0] d,
                      input logic [15:0] e, input bit push);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_clr = c; cmd_op = op; cmd_data = d;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    if (push) sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100 && !(sb.size() == 0 && cmd_ready && !rsp_valid); i++) @(negedge clk);
    chk("idle_timeout", {31'd0, sb.size() == 0 && cmd_ready}, 32'd1);
  endtask

  typedef struct {
    logic        clr;
    logic [2:0]  op;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t        v[9];
    logic [15:0] last_sw;
    int          t[3], n, hi, rise;
    logic        prev;

    v[0] = '{1'b1, 3'b000, 16'hbeef, 16'h0000};
    v[1] = '{1'b0, 3'b010, 16'h354a, 16'h354a};
    v[2] = '{1'b0, 3'b011, 16'h1234, 16'h2316};
    v[3] = '{1'b0, 3'b001, 16'h1001, 16'h3317};
    v[4] = '{1'b0, 3'b000, 16'hf0f0, 16'h3010};
    v[5] = '{1'b0, 3'b111, 16'h00ff, 16'h30ef};
    v[6] = '{1'b0, 3'b101, 16'h0004, 16'h0ef0};
    v[7] = '{1'b0, 3'b011, 16'h1000, 16'hfef0};
    v[8] = '{1'b0, 3'b110, 16'h0004, 16'hffef};

    #12;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("rst_buttons", {27'd0, btnl, btnc, btnr, btnd, btnu}, 32'd0);
    chk("rst_sw", {16'd0, sw}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    last_sw = 16'h0000;
    for (int k = 0; k < 9; k++) begin
      send(v[k].clr, v[k].op, v[k].data, v[k].exp, 1'b1);
      if (!v[k].clr) last_sw = v[k].data;
      chk("vec_sw", {16'd0, sw}, {16'd0, last_sw});
      if (!v[k].clr) chk("vec_op", {29'd0, btnl, btnc, btnr}, {29'd0, v[k].op});
      wait_idle();
    end

    // phase timing: accept edge is cycle 0, values sampled on the negedge before edge k are cycle k
    @(negedge clk);
    cmd_valid = 1'b1; cmd_clr = 1'b0; cmd_op = 3'b010; cmd_data = 16'h0000;
    sb.push_back(16'hffef);
    prev = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (k == 1) chk("t_sw_cyc1", {16'd0, sw}, 32'd0);
      chk($sformatf("t_btnd_c%0d", k), {31'd0, btnd}, {31'd0, k >= S + 1 && k <= S + P});
      chk($sformatf("t_btnu_c%0d", k), {31'd0, btnu}, 32'd0);
      if (rsp_valid && !prev) chk("t_rsp_rise", k, S + P + T + 1);
      prev = rsp_valid;
    end
    wait_idle();

    // backpressure with an ignored clear in the window
    rsp_ready = 1'b0;
    send(1'b0, 3'b001, 16'h0000, 16'hffef, 1'b1);
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin cmd_valid = 1'b1; cmd_clr = 1'b1; end
      if (i == 2) cmd_valid = 1'b0;
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_data", {16'd0, rsp_data}, 32'h0000ffef);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_clr = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    send(1'b0, 3'b010, 16'h0000, 16'hffef, 1'b1);
    wait_idle();

    // reset mid-pulse drops the transaction
    send(1'b0, 3'b010, 16'h1111, 16'h0000, 1'b0);
    for (int i = 0; i < 20 && !btnd; i++) @(negedge clk);
    chk("mid_btnd_seen", {31'd0, btnd}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_btnd", {31'd0, btnd}, 32'd0);
    chk("mid_sw", {16'd0, sw}, 32'd0);
    chk("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (15) @(negedge clk);
    chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // back-to-back operations
    send(1'b1, 3'b000, 16'h0000, 16'h0000, 1'b1);
    wait_idle();
    cmd_clr = 1'b0; cmd_op = 3'b010; cmd_data = 16'h0001;
    n = 0; hi = 0; rise = 0; prev = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    for (int c = 0; c < 60 && n < 3; c++) begin
      if (c > 0) @(negedge clk);
      hi += int'(btnd);
      rise += int'(btnd && !prev);
      prev = btnd;
      if (cmd_ready) begin
        t[n] = c;
        n++;
        sb.push_back(16'(n));
      end
    end
    chk("b2b_accepts", n, 3);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      hi += int'(btnd);
      rise += int'(btnd && !prev);
      prev = btnd;
      @(negedge clk);
    end
    chk("b2b_gap1", t[1] - t[0], S + P + T + 2);
    chk("b2b_gap2", t[2] - t[1], S + P + T + 2);
    chk("b2b_pulses", rise, 3);
    chk("b2b_high", hi, 3 * P);
    wait_idle();

`ifdef CALC_DRV_OPCOUNT_EN
    chk("opcnt_three", {16'd0, op_count}, 32'd3);
    send(1'b1, 3'b000, 16'h0000, 16'h0000, 1'b1);
    wait_idle();
    chk("opcnt_clear", {16'd0, op_count}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
